// File: rtl/excess3_pkg.sv
// Shared types and constants for the Excess-3 arithmetic blocks.
// Holds the controller state encoding and the digit-range helper.
package excess3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] X3_BIAS = 4'b0011;
    localparam logic [3:0] X3_MIN  = 4'b0011;
    localparam logic [3:0] X3_MAX  = 4'b1100;

    // A packed Excess-3 digit is legal only for decimal 0..9 (0011..1100).
    function automatic logic x3_valid(input logic [3:0] digit);
        return (digit >= X3_MIN) && (digit <= X3_MAX);
    endfunction

endpackage

// File: rtl/excess3_digit_adder.sv
// One-digit Excess-3 adder with decimal carry and Excess-3 re-biasing.
// Shared by the subtract pass and the re-complement pass.
module excess3_digit_adder
    import excess3_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] s;

    assign s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};

    // Two biased operands carry +6; a decimal carry leaves -10 behind so we
    // restore +3, otherwise we strip the extra +3.
    assign cout  = s[4];
    assign digit = s[4] ? (s[3:0] + X3_BIAS) : (s[3:0] - X3_BIAS);

endmodule

// File: rtl/excess3_serial_subtractor.sv
// Digit-serial Excess-3 subtractor: A + nines(B) + 1, LSD first, then an
// optional ten's-complement pass to return |A-B| with a separate sign.
module excess3_serial_subtractor
    import excess3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a_x3,
    input  logic [4*DIGITS-1:0]   b_x3,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   diff_x3,
    output logic [4*DIGITS-1:0]   diff_bcd,
    output logic                  neg,
    output logic                  invalid
);

    localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t                 state;
    state_t                 state_nxt;

    logic [DIGITS-1:0][3:0] a_q;
    logic [DIGITS-1:0][3:0] b_q;
    logic [DIGITS-1:0][3:0] r_x3;
    logic [DIGITS-1:0][3:0] r_bcd;
    logic [IDX_W-1:0]       idx;
    logic                   cin;
    logic                   neg_q;
    logic                   invalid_q;

    logic                   operand_bad;
    logic                   last;
    logic [3:0]             add_x;
    logic [3:0]             add_y;
    logic [3:0]             sum_digit;
    logic                   sum_cout;

    assign last = (idx == LAST_IDX);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        operand_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!x3_valid(a_x3[4*i +: 4]) || !x3_valid(b_x3[4*i +: 4]))
                operand_bad = 1'b1;
        end
    end

    // SUB adds the nine's complement of B; NEG adds Excess-3 zero to the
    // nine's complement of the partial result, giving its ten's complement.
    always_comb begin
        add_x = a_q[idx];
        add_y = ~b_q[idx];
        if (state == NEG) begin
            add_x = ~r_x3[idx];
            add_y = X3_BIAS;
        end
    end

    excess3_digit_adder u_digit_adder (
        .x     (add_x),
        .y     (add_y),
        .cin   (cin),
        .digit (sum_digit),
        .cout  (sum_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = operand_bad ? DONE : SUB;
            end
            SUB: begin
                if (last)
                    state_nxt = sum_cout ? DONE : NEG;
            end
            NEG: begin
                if (last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the operand latches and result digits sit on the synchronous reset
    // too, since an aborted operation must leave all visible outputs at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            r_x3      <= '0;
            r_bcd     <= '0;
            idx       <= '0;
            cin       <= 1'b0;
            neg_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a_x3;
                        b_q       <= b_x3;
                        r_x3      <= '0;
                        r_bcd     <= '0;
                        idx       <= '0;
                        cin       <= 1'b1;
                        neg_q     <= 1'b0;
                        invalid_q <= operand_bad;
                    end
                end
                SUB, NEG: begin
                    r_x3[idx]  <= sum_digit;
                    r_bcd[idx] <= sum_digit - X3_BIAS;
                    cin        <= sum_cout;
                    idx        <= last ? '0 : idx + 1'b1;
                    // No final carry means A<B: rerun over the result as +1.
                    if ((state == SUB) && last && !sum_cout) begin
                        neg_q <= 1'b1;
                        cin   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff_x3  = r_x3;
    assign diff_bcd = r_bcd;
    assign neg      = neg_q;
    assign invalid  = invalid_q;

endmodule

// File: tb/tb_excess3_serial_subtractor.sv
// Self-checking bench for excess3_serial_subtractor (DIGITS=4): directed
// vectors, hand-written control sequences and randomized operations.
module tb_excess3_serial_subtractor;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   a_x3 = '0;
    logic [15:0]   b_x3 = '0;
    logic          busy, done, neg, invalid;
    logic [15:0]   diff_x3, diff_bcd;

    int checks = 0;
    int errors = 0;

    excess3_serial_subtractor #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_x3     (a_x3),
        .b_x3     (b_x3),
        .busy     (busy),
        .done     (done),
        .diff_x3  (diff_x3),
        .diff_bcd (diff_bcd),
        .neg      (neg),
        .invalid  (invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] ex3;
        logic [15:0] ebcd;
        logic        eneg;
        logic        einv;
        int          elat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: decode to integers, subtract, encode the magnitude.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] ex3, output logic [15:0] ebcd,
                                  output logic eneg, output logic einv, output int elat);
        int av = 0;
        int bv = 0;
        int d;
        logic [3:0] da, db;
        einv = 1'b0;
        for (int i = D - 1; i >= 0; i--) begin
            da = a[i*4 +: 4];
            db = b[i*4 +: 4];
            if (da < 4'd3 || da > 4'd12 || db < 4'd3 || db > 4'd12) einv = 1'b1;
            av = av * 10 + int'(da) - 3;
            bv = bv * 10 + int'(db) - 3;
        end
        ex3  = '0;
        ebcd = '0;
        eneg = 1'b0;
        if (einv) begin
            elat = 1;
        end else begin
            d    = av - bv;
            eneg = (d < 0);
            if (d < 0) d = -d;
            for (int i = 0; i < D; i++) begin
                ebcd[i*4 +: 4] = 4'(d % 10);
                ex3[i*4 +: 4]  = 4'(d % 10 + 3);
                d = d / 10;
            end
            elat = eneg ? 2*D + 1 : D + 1;
        end
    endfunction

    // Drives start for one edge; returns at the falling edge of cycle 1.
    task automatic pulse_start(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a_x3  = a;
        b_x3  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int first_cyc, output int cyc);
        cyc = first_cyc;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ex3, input logic [15:0] ebcd,
                          input logic eneg, input logic einv, input int elat);
        int cyc;
        pulse_start(a, b);
        wait_done(1, cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        check({tag, "_diff_x3"}, 32'(diff_x3), 32'(ex3));
        check({tag, "_diff_bcd"}, 32'(diff_bcd), 32'(ebcd));
        check({tag, "_neg"}, 32'(neg), 32'(eneg));
        check({tag, "_invalid"}, 32'(invalid), 32'(einv));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(diff_x3), 32'(ex3));
    endtask

    initial begin
        vec_t vecs[8];
        int cyc;
        int n_done, n_idle;
        logic [15:0] ra, rb, ex3, ebcd;
        logic eneg, einv;
        int elat;

        vecs[0] = '{16'h3375, 16'h334A, 16'h3358, 16'h0025, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h334A, 16'h3375, 16'h3358, 16'h0025, 1'b1, 1'b0, 9};
        vecs[2] = '{16'h3C6B, 16'h3C6B, 16'h3333, 16'h0000, 1'b0, 1'b0, 5};
        vecs[3] = '{16'h3333, 16'hCCCC, 16'hCCCC, 16'h9999, 1'b1, 1'b0, 9};
        vecs[4] = '{16'h3370, 16'h3333, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
        vecs[5] = '{16'h3375, 16'h334A, 16'h3358, 16'h0025, 1'b0, 1'b0, 5};
        vecs[6] = '{16'hCCCC, 16'h3333, 16'hCCCC, 16'h9999, 1'b0, 1'b0, 5};
        vecs[7] = '{16'h3375, 16'h3D33, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff_x3", 32'(diff_x3), 32'd0);
        check("reset_diff_bcd", 32'(diff_bcd), 32'd0);
        check("reset_neg", 32'(neg), 32'd0);
        check("reset_invalid", 32'(invalid), 32'd0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ex3,
                   vecs[i].ebcd, vecs[i].eneg, vecs[i].einv, vecs[i].elat);

        // Starts during SUB and during DONE must be ignored.
        pulse_start(16'h3375, 16'h334A);
        @(negedge clk);
        a_x3  = 16'h3333;
        b_x3  = 16'hCCCC;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, cyc);
        check("ign_latency", 32'(cyc), 32'd5);
        check("ign_diff_x3", 32'(diff_x3), 32'h3358);
        check("ign_neg", 32'(neg), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("ign_done_start", 32'(busy), 32'd0);
        check("ign_hold_bcd", 32'(diff_bcd), 32'h0025);

        // Reset in the middle of a negative subtraction.
        pulse_start(16'h334A, 16'h3375);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff_x3", 32'(diff_x3), 32'd0);
        check("abort_diff_bcd", 32'(diff_bcd), 32'd0);
        check("abort_neg", 32'(neg), 32'd0);
        check("abort_invalid", 32'(invalid), 32'd0);
        run_op("after_abort", 16'h334A, 16'h3375, 16'h3358, 16'h0025, 1'b1, 1'b0, 9);

        // start held high: one accepted op per IDLE visit, 6-cycle period.
        @(negedge clk);
        a_x3   = 16'h3375;
        b_x3   = 16'h334A;
        start  = 1'b1;
        n_done = 0;
        n_idle = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                check("b2b_diff", 32'(diff_x3), 32'h3358);
            end
            if (busy === 1'b0) n_idle++;
        end
        start = 1'b0;
        check("b2b_done_count", 32'(n_done), 32'd5);
        check("b2b_idle_count", 32'(n_idle), 32'd5);
        repeat (8) @(negedge clk);

        // Randomized operands against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < D; i++) begin
                ra[i*4 +: 4] = 4'($urandom_range(3, 12));
                rb[i*4 +: 4] = 4'($urandom_range(3, 12));
            end
            if ($urandom_range(0, 7) == 0)
                ra[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(13, 18));
            model(ra, rb, ex3, ebcd, eneg, einv, elat);
            run_op($sformatf("rnd%0d", n), ra, rb, ex3, ebcd, eneg, einv, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
